// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: fixed-priority share of the single-port data memory between core and host port.
// Latency: grant is combinational, writes land at the grant edge, read data returns 1 cycle after grant.
// Backpressure: core_gnt/host_ready drop when the other side wins; returns never stall; host gets a forced grant after STARVE_MAX losses.
//
// Ports:
//   clk, reset                 clock and synchronous active-low reset
//   core_req/we/addr/wdata     core request; core_gnt accepts it (combinational)
//   core_rvalid/core_rdata     core read return, one cycle after the read grant
//   host_valid/we/addr/wdata   host request; host_ready accepts it (combinational)
//   host_rvalid/host_rdata     host read return, one cycle after the read grant
//   mem_en/we/addr/wdata/rdata single-port synchronous memory interface
//   busy                       any request pending or read outstanding
// Optional build macro DM_ARB_PERF_CNT_EN adds core_gnt_cnt, host_gnt_cnt and conflict_cnt.
module dm_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef DM_ARB_PERF_CNT_EN
    output logic [15:0]   core_gnt_cnt,
    output logic [15:0]   host_gnt_cnt,
    output logic [15:0]   conflict_cnt,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rd_owner_t     rd_owner;
    rd_owner_t     rd_owner_nxt;
    logic [3:0]    starve_cnt;
    logic          force_host;
    logic          core_sel;
    logic          host_sel;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] host_rdata_q;

    // Grant selection; everything is suppressed while reset is asserted.
    always_comb begin
        force_host = host_valid && (starve_cnt == STARVE_LIM);
        core_sel   = 1'b0;
        host_sel   = 1'b0;
        if (reset) begin
            if (force_host) begin
                host_sel = 1'b1;
            end else if (core_req) begin
                core_sel = 1'b1;
            end else if (host_valid) begin
                host_sel = 1'b1;
            end
        end
    end

    assign core_gnt   = core_sel;
    assign host_ready = host_sel;

    always_comb begin
        mem_en    = core_sel || host_sel;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_sel) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_sel) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Host loses a cycle whenever it is valid but the core holds the grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (host_sel) begin
            starve_cnt <= '0;
        end else if (host_valid && core_sel && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read-owner tracking: one state per in-flight read, reloaded every edge so
    // back-to-back reads pipeline without bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt = RD_NONE;
        if (core_sel && !core_we) begin
            rd_owner_nxt = RD_CORE;
        end else if (host_sel && !host_we) begin
            rd_owner_nxt = RD_HOST;
        end
    end

    // mem_rdata is valid in the cycle rd_owner names the reader; the holding
    // registers keep each side's last returned word when it is not selected.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            if (rd_owner == RD_CORE) begin
                core_rdata_q <= mem_rdata;
            end
            if (rd_owner == RD_HOST) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    // Qualifying with reset drops a return whose read was granted just before
    // reset was asserted.
    assign core_rvalid = reset && (rd_owner == RD_CORE);
    assign host_rvalid = reset && (rd_owner == RD_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;

    assign busy = core_req || host_valid || (rd_owner != RD_NONE);

`ifdef DM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_gnt_cnt <= '0;
            host_gnt_cnt <= '0;
            conflict_cnt <= '0;
        end else begin
            if (core_sel && (core_gnt_cnt != 16'hFFFF)) begin
                core_gnt_cnt <= core_gnt_cnt + 16'd1;
            end
            if (host_sel && (host_gnt_cnt != 16'hFFFF)) begin
                host_gnt_cnt <= host_gnt_cnt + 16'd1;
            end
            if (core_req && host_valid && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed bench for dm_port_arbiter with a behavioural single-port memory.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
// Backpressure: fixed-length directed cycles only, so the run always ends.
module tb_dm_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata;
    logic       core_gnt, core_rvalid;
    logic [7:0] core_rdata;
    logic       host_valid, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_ready, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
`ifdef DM_ARB_PERF_CNT_EN
    logic [15:0] core_gnt_cnt, host_gnt_cnt, conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_valid  (host_valid),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
`ifdef DM_ARB_PERF_CNT_EN
        .core_gnt_cnt(core_gnt_cnt),
        .host_gnt_cnt(host_gnt_cnt),
        .conflict_cnt(conflict_cnt),
`endif
        .busy        (busy)
    );

    // Single-port synchronous memory: write at the enable edge, read data next cycle.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle's drive point.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drv(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic host_drv(input logic vld, input logic we, input logic [7:0] a, input logic [7:0] d);
        host_valid = vld; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        reset = 1'b0;
        core_drv(1'b1, 1'b0, 8'h00, 8'h00);
        host_drv(1'b1, 1'b0, 8'h00, 8'h00);

        // Reset held for two edges with both requesters active.
        next_cyc();
        next_cyc();
        #3;
        chk("rst_core_gnt",   core_gnt,    0);
        chk("rst_host_ready", host_ready,  0);
        chk("rst_mem_en",     mem_en,      0);
        chk("rst_mem_we",     mem_we,      0);
        chk("rst_core_rvalid",core_rvalid, 0);
        chk("rst_host_rvalid",host_rvalid, 0);
        chk("rst_busy_req",   busy,        1);
        chk("rst_core_rdata", core_rdata,  8'h00);
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_busy_idle",  busy,        0);
        next_cyc();
        reset = 1'b1;

        // Core-only write then read of addr 3.
        core_drv(1'b1, 1'b1, 8'd3, 8'hF0);
        #3;
        chk("cw_gnt",   core_gnt,  1);
        chk("cw_we",    mem_we,    1);
        chk("cw_addr",  mem_addr,  8'd3);
        chk("cw_wdata", mem_wdata, 8'hF0);
        next_cyc();
        core_drv(1'b1, 1'b0, 8'd3, 8'h00);
        #3;
        chk("cr_gnt",        core_gnt,    1);
        chk("cr_mem_we",     mem_we,      0);
        chk("cr_no_rvalid",  core_rvalid, 0);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("cr_rvalid",     core_rvalid, 1);
        chk("cr_rdata",      core_rdata,  8'hF0);
        chk("cr_host_rvld",  host_rvalid, 0);
        chk("cr_busy_out",   busy,        1);
        chk("cr_idle_mem_en",mem_en,      0);
        chk("cr_idle_addr",  mem_addr,    8'h00);
        next_cyc();
        #3;
        chk("cr_rvalid_pulse", core_rvalid, 0);
        chk("cr_rdata_hold",   core_rdata,  8'hF0);
        chk("cr_busy_clear",   busy,        0);
        next_cyc();

        // Host preload addr 6/7 then read both back-to-back.
        host_drv(1'b1, 1'b1, 8'd6, 8'hAA);
        #3; chk("hw6_ready", host_ready, 1);
        next_cyc();
        host_drv(1'b1, 1'b1, 8'd7, 8'h55);
        #3; chk("hw7_ready", host_ready, 1);
        next_cyc();
        host_drv(1'b1, 1'b0, 8'd6, 8'h00);
        #3; chk("hr6_ready", host_ready, 1);
        next_cyc();
        host_drv(1'b1, 1'b0, 8'd7, 8'h00);
        #3;
        chk("hr7_ready",  host_ready,  1);
        chk("hr6_rvalid", host_rvalid, 1);
        chk("hr6_rdata",  host_rdata,  8'hAA);
        next_cyc();
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("hr7_rvalid", host_rvalid, 1);
        chk("hr7_rdata",  host_rdata,  8'h55);
        chk("hr_no_core", core_rvalid, 0);
        next_cyc();
        #3;
        chk("hr_rvalid_pulse", host_rvalid, 0);
        chk("hr_rdata_hold",   host_rdata,  8'h55);
        chk("hr_core_hold",    core_rdata,  8'hF0);
        next_cyc();

        // Starvation: core writes every cycle while host read of addr 6 waits.
        core_drv(1'b1, 1'b1, 8'd10, 8'h11);
        host_drv(1'b1, 1'b0, 8'd6, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            #3;
            chk($sformatf("stv_core_gnt%0d", k), core_gnt,   1);
            chk($sformatf("stv_host_rdy%0d", k), host_ready, 0);
            next_cyc();
        end
        #3;
        chk("stv_force_core", core_gnt,   0);
        chk("stv_force_host", host_ready, 1);
        chk("stv_force_addr", mem_addr,   8'd6);
        next_cyc();
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("stv_rvalid",  host_rvalid, 1);
        chk("stv_rdata",   host_rdata,  8'hAA);
        chk("stv_core_bk", core_gnt,    1);
        next_cyc();
        // Counter cleared by the forced grant: core wins again.
        host_drv(1'b1, 1'b0, 8'd6, 8'h00);
        #3;
        chk("stv_cleared_core", core_gnt,   1);
        chk("stv_cleared_host", host_ready, 0);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        next_cyc();

        // Same-address conflict: core read and host write of addr 3 together.
        core_drv(1'b1, 1'b0, 8'd3, 8'h00);
        host_drv(1'b1, 1'b1, 8'd3, 8'h33);
        #3;
        chk("cf_core_gnt", core_gnt,   1);
        chk("cf_host_rdy", host_ready, 0);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("cf_host_now",  host_ready, 1);
        chk("cf_old_data",  core_rdata, 8'hF0);
        chk("cf_old_rvld",  core_rvalid,1);
        next_cyc();
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        core_drv(1'b1, 1'b0, 8'd3, 8'h00);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("raw_new_data", core_rdata, 8'h33);
        next_cyc();

        // Interleaved reads: preload addr 0/1, then core read N, host read N+1.
        core_drv(1'b1, 1'b1, 8'd0, 8'hF0);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        host_drv(1'b1, 1'b1, 8'd1, 8'h01);
        next_cyc();
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        core_drv(1'b1, 1'b0, 8'd0, 8'h00);
        next_cyc();
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        host_drv(1'b1, 1'b0, 8'd1, 8'h00);
        #3;
        chk("il_core_rvalid", core_rvalid, 1);
        chk("il_core_rdata",  core_rdata,  8'hF0);
        chk("il_host_nrv",    host_rvalid, 0);
        chk("il_host_rdy",    host_ready,  1);
        next_cyc();
        host_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("il_host_rvalid", host_rvalid, 1);
        chk("il_host_rdata",  host_rdata,  8'h01);
        chk("il_core_nrv",    core_rvalid, 0);
        chk("il_core_hold",   core_rdata,  8'hF0);
        next_cyc();

        // Reset asserted right after a core read grant.
        core_drv(1'b1, 1'b0, 8'd0, 8'h00);
        #3;
        chk("rmr_gnt", core_gnt, 1);
        next_cyc();
        reset = 1'b0;
        core_drv(1'b0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("rmr_no_rvalid", core_rvalid, 0);
        next_cyc();
        reset = 1'b1;
        #3;
        chk("rmr_no_rvalid2", core_rvalid, 0);
        chk("rmr_owner_none", busy,        0);
        chk("rmr_rdata_clr",  core_rdata,  8'h00);
`ifdef DM_ARB_PERF_CNT_EN
        chk("rmr_core_cnt", core_gnt_cnt, 0);
        chk("rmr_host_cnt", host_gnt_cnt, 0);
        chk("rmr_conf_cnt", conflict_cnt, 0);
`endif
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port synchronous data memory (dm1) between two requesters: the core load/store path and a host loader/debug port used by benches and boot code to preload or inspect memory.
- Sits between the core, the host port and dm1.
- Core has fixed priority; a starvation counter guarantees host forward progress.
- Read data returns one cycle after grant, tagged to the requester that issued the read.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- STARVE_MAX, 4, consecutive host-lost cycles before the host is forced a grant (legal range 1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- core_req  input  1  core access request this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  AW  core address
- core_wdata  input  DW  core write data
- core_gnt  output  1  core request accepted this cycle (combinational)
- core_rvalid  output  1  core read data valid (registered)
- core_rdata  output  DW  core read data
- host_valid  input  1  host request valid
- host_we  input  1  1 = write, 0 = read
- host_addr  input  AW  host address
- host_wdata  input  DW  host write data
- host_ready  output  1  host request accepted this cycle (combinational); transfer occurs when host_valid && host_ready
- host_rvalid  output  1  host read data valid (registered)
- host_rdata  output  DW  host read data
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0
- busy  output  1  1 while any read is outstanding or any request is pending

Behaviour:
- Reset (reset==0 at a clock edge):
  - starve_cnt=0, rd_owner=NONE.
  - core_rvalid=0, host_rvalid=0; core_rdata and host_rdata = 0.
  - During reset, core_gnt=0, host_ready=0, mem_en=0, mem_we=0.
- Grant selection is combinational each cycle:
  - force_host = host_valid && (starve_cnt == STARVE_MAX).
  - If force_host: host granted, core_gnt=0.
  - Else if core_req: core granted.
  - Else if host_valid: host granted.
  - Else: no grant.
- Memory port:
  - mem_en = any grant.
  - mem_we, mem_addr and mem_wdata come from the granted requester.
  - With no grant, mem_addr and mem_wdata = 0.
- starve_cnt, registered:
  - Clears on any host grant.
  - Increments when host_valid && core_gnt, saturating at STARVE_MAX.
  - Holds otherwise, including when host_valid drops without a grant.
- Read tracking: rd_owner FSM with states NONE, CORE, HOST, updated every edge.
  - Next state = CORE on a core read grant, HOST on a host read grant, NONE on a write grant or no grant.
  - Back-to-back reads are fully pipelined: one new read per cycle, no bubbles.
- Read return, registered in the cycle after grant:
  - core_rvalid = (rd_owner==CORE); host_rvalid = (rd_owner==HOST).
  - The selected rdata output is driven from mem_rdata. The other rdata output holds its last value.
  - rvalid pulses last one cycle.
- Latency:
  - Write completes at the grant edge.
  - Read data appears exactly 1 cycle after grant, with no backpressure on returns.
- Simultaneous events:
  - A host write and a core read on the same address in the same cycle are serialized by priority.
  - A read of an address written in the previous cycle returns the new data.
- Reset mid-read: an outstanding read is dropped, no rvalid is issued after reset, and rd_owner=NONE.
- busy = core_req || host_valid || (rd_owner != NONE).
- Host protocol rule: host_valid and its payload must stay stable until host_ready. A violation is not checked.

Optional Feature:
- Macro: DM_ARB_PERF_CNT_EN.
- When defined, three extra outputs are added, each 16 bits and saturating at 16'hFFFF, cleared by reset:
  - core_gnt_cnt, incremented per core grant.
  - host_gnt_cnt, incremented per host grant.
  - conflict_cnt, incremented per cycle with core_req && host_valid.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with core_req=1 and host_valid=1 -> core_gnt=0, host_ready=0, mem_en=0, both rvalid=0, busy reflects only the inputs.
- Core-only: write 8'hF0 to addr 3, then read addr 3 -> core_rvalid high exactly 1 cycle after the read grant, core_rdata=8'hF0, host_rvalid stays 0.
- Host preload: host writes 8'hAA to addr 6 and 8'h55 to addr 7 back-to-back, then reads both -> host_ready=1 every cycle, host_rdata=8'hAA then 8'h55 on consecutive cycles.
- Starvation: core_req=1 continuously with host read of addr 6 pending, STARVE_MAX=4 -> core granted 4 cycles, host granted on cycle 5 with core_gnt=0, host_rdata=8'hAA on cycle 6, starve_cnt=0.
- Interleaved reads: core reads addr 0 in cycle N, host reads addr 1 in cycle N+1 -> core_rvalid at N+1 with 8'hF0, host_rvalid at N+2 with 8'h01, no cross-delivery.
- Reset mid-read: core read granted, reset=0 on the next edge -> no core_rvalid pulse, rd_owner=NONE; with DM_ARB_PERF_CNT_EN defined, all counters read 0.
